hazard_ctrl_p: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Generates stall, flush and freeze controls for the pipeline registers and PC, plus EX-stage and ID-stage forwarding selects.
- Generalises the single-cycle load-use case to a configurable load latency.
- Adds branch-flush, jump-flush, external-freeze and saturating hazard performance counters.

---
 rtl/hazard_ctrl_p.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl_p.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_p.sv
// hazard_ctrl_p: load-use stall, branch/jump flush, external freeze and EX/ID forwarding selects.
// Controls are combinational from state and inputs (zero latency); ext_stall freezes all state except clr_cnt.
module hazard_ctrl_p #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0] ex_rt,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic            br_taken,
  input  logic            jump_id,
  input  logic            ext_stall,
  input  logic            clr_cnt,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            pipe_freeze,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            id_fwd_a,
  output logic            id_fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int LC_W = $clog2(LOAD_LAT + 1);

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t           state_q, state_d;
  logic [LC_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu, inc_stall, inc_flush;
  logic             mem_fwd_ok, wb_fwd_ok;

  assign lu = ex_memread & ex_regwrite & (ex_rd != '0) &
              ((id_uses_rs & (ex_rd == id_rs)) | (id_uses_rt & (ex_rd == id_rt)));

  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    inc_stall   = 1'b0;
    inc_flush   = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (ext_stall) begin
      pipe_freeze = 1'b1;
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
    end else if (br_taken) begin
      // wrong-path instructions are discarded, so any pending load-use stall is moot
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      lu_cnt_d   = '0;
      inc_flush  = 1'b1;
    end else if (state_q == LU_STALL) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      inc_stall  = 1'b1;
      lu_cnt_d   = lu_cnt_q - LC_W'(1);
      if (lu_cnt_q <= LC_W'(1)) begin
        state_d  = RUN;
        lu_cnt_d = '0;
      end
    end else if (lu) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      inc_stall  = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d  = LU_STALL;
        lu_cnt_d = LC_W'(LOAD_LAT - 1);
      end
    end else if (jump_id) begin
      ifid_flush = 1'b1;
      inc_flush  = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (inc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (inc_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // a load still in MEM has no data yet; it can only be bypassed once it reaches WB
  assign mem_fwd_ok = mem_regwrite & ~mem_memread & (mem_rd != '0);
  assign wb_fwd_ok  = wb_regwrite & (wb_rd != '0);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_fwd_ok && (mem_rd == ex_rs))     fwd_a = 2'b10;
    else if (wb_fwd_ok && (wb_rd == ex_rs))  fwd_a = 2'b01;
    if (mem_fwd_ok && (mem_rd == ex_rt))     fwd_b = 2'b10;
    else if (wb_fwd_ok && (wb_rd == ex_rt))  fwd_b = 2'b01;
  end

  assign id_fwd_a = wb_fwd_ok & (wb_rd == id_rs);
  assign id_fwd_b = wb_fwd_ok & (wb_rd == id_rt);

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Bench for hazard_ctrl_p: three instances (LOAD_LAT=1, LOAD_LAT=3, 4-bit counters) share one stimulus.
// Expected values are queued as stimulus is driven and drained at the negedge sample point.
module tb_hazard_ctrl_p;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, ex_regwrite, ex_memread;
  logic       mem_regwrite, mem_memread, wb_regwrite;
  logic       br_taken, jump_id, ext_stall, clr_cnt;

  logic       a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush, a_pipe_freeze, a_id_fwd_a, a_id_fwd_b;
  logic       b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_flush, b_pipe_freeze, b_id_fwd_a, b_id_fwd_b;
  logic       s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_flush, s_pipe_freeze, s_id_fwd_a, s_id_fwd_b;
  logic [1:0] a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b, s_fwd_a, s_fwd_b;
  logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_p #(.RA_W(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .br_taken(br_taken), .jump_id(jump_id), .ext_stall(ext_stall), .clr_cnt(clr_cnt),
    .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
    .pipe_freeze(a_pipe_freeze), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .id_fwd_a(a_id_fwd_a), .id_fwd_b(a_id_fwd_b),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  hazard_ctrl_p #(.RA_W(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .br_taken(br_taken), .jump_id(jump_id), .ext_stall(ext_stall), .clr_cnt(clr_cnt),
    .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
    .pipe_freeze(b_pipe_freeze), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .id_fwd_a(b_id_fwd_a), .id_fwd_b(b_id_fwd_b),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  hazard_ctrl_p #(.RA_W(5), .LOAD_LAT(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .br_taken(br_taken), .jump_id(jump_id), .ext_stall(ext_stall), .clr_cnt(clr_cnt),
    .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .pipe_freeze(s_pipe_freeze), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .id_fwd_a(s_id_fwd_a), .id_fwd_b(s_id_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  // control bundle order: {pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze}
  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b11010;
  localparam logic [4:0] BRF   = 5'b00110;
  localparam logic [4:0] JMP   = 5'b00100;
  localparam logic [4:0] FRZ   = 5'b11001;

  typedef struct {
    string       name;
    int          which;
    int          kind;
    logic [15:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [15:0] mk(input logic [4:0] c, input logic [1:0] fa, input logic [1:0] fb,
                                     input logic ia, input logic ib);
    return {5'b0, c, fa, fb, ia, ib};
  endfunction

  function automatic logic [15:0] observe(input int w, input int k);
    logic [10:0] c;
    logic [15:0] s, f;
    case (w)
      1: begin
        c = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush, a_pipe_freeze, a_fwd_a, a_fwd_b, a_id_fwd_a, a_id_fwd_b};
        s = a_stall_cnt; f = a_flush_cnt;
      end
      3: begin
        c = {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_flush, b_pipe_freeze, b_fwd_a, b_fwd_b, b_id_fwd_a, b_id_fwd_b};
        s = b_stall_cnt; f = b_flush_cnt;
      end
      default: begin
        c = {s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_flush, s_pipe_freeze, s_fwd_a, s_fwd_b, s_id_fwd_a, s_id_fwd_b};
        s = {12'b0, s_stall_cnt}; f = {12'b0, s_flush_cnt};
      end
    endcase
    if (k == 0) return {5'b0, c};
    if (k == 1) return s;
    return f;
  endfunction

  task automatic expect_val(input string n, input int w, input int k, input logic [15:0] v);
    exp_t e;
    e.name = n; e.which = w; e.kind = k; e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; mem_memread = 0; wb_rd = 0; wb_regwrite = 0;
    br_taken = 0; jump_id = 0; ext_stall = 0; clr_cnt = 0;
  endtask

  // lw $8 in EX, add $9,$8,$10 in ID
  task automatic set_lu();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 8;
    id_rs = 8; id_uses_rs = 1; id_rt = 10; id_uses_rt = 1;
  endtask

  task automatic settle_clear();
    idle();
    clr_cnt = 1;
    repeat (3) @(posedge clk);
    #1 clr_cnt = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [15:0] got;
    reset = 0;
    idle();
    set_lu();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        @(posedge clk); #1;
        reset = 1;
        idle();
      end
      if (i == 0) begin
        expect_val("rst_ctrl_lat1", 1, 0, mk(STALL, 2'b00, 2'b00, 0, 0));
        expect_val("rst_ctrl_lat3", 3, 0, mk(STALL, 2'b00, 2'b00, 0, 0));
      end else begin
        expect_val("rst_rel_ctrl", 3, 0, mk(NONE, 2'b00, 2'b00, 0, 0));
      end
      expect_val("rst_stall_cnt", 3, 1, 16'd0);
      expect_val("rst_flush_cnt", 1, 2, 16'd0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = observe(e.which, e.kind); checks++;
        if (got !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, got, e.value); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use_lat1();
    exp_t e;
    logic [15:0] got;
    settle_clear();
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin
          set_lu();
          expect_val("lat1_hazard_ctrl", 1, 0, mk(STALL, 2'b00, 2'b00, 0, 0));
          expect_val("lat1_cnt_before", 1, 1, 16'd0);
        end
        1: begin
          mem_rd = 8; mem_memread = 1; mem_regwrite = 1; id_rs = 8; id_uses_rs = 1;
          expect_val("lat1_released", 1, 0, mk(NONE, 2'b00, 2'b00, 0, 0));
          expect_val("lat1_stall_cnt", 1, 1, 16'd1);
        end
        default: begin
          ex_rs = 8; ex_rt = 10; wb_rd = 8; wb_regwrite = 1;
          expect_val("lat1_wb_fwd", 1, 0, mk(NONE, 2'b01, 2'b00, 0, 0));
          expect_val("lat1_stall_hold", 1, 1, 16'd1);
          expect_val("lat1_flush_cnt", 1, 2, 16'd0);
        end
      endcase
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = observe(e.which, e.kind); checks++;
        if (got !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, got, e.value); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use_lat3_jump();
    exp_t e;
    logic [15:0] got;
    settle_clear();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i == 0) set_lu();
      if (i >= 1 && i <= 3) jump_id = 1;
      case (i)
        0, 1, 2: expect_val("lat3_stall", 3, 0, mk(STALL, 2'b00, 2'b00, 0, 0));
        3:       expect_val("lat3_jump_after", 3, 0, mk(JMP, 2'b00, 2'b00, 0, 0));
        default: expect_val("lat3_run", 3, 0, mk(NONE, 2'b00, 2'b00, 0, 0));
      endcase
      expect_val("lat3_stall_cnt", 3, 1, (i < 3) ? 16'(i) : 16'd3);
      expect_val("lat3_flush_cnt", 3, 2, (i == 4) ? 16'd1 : 16'd0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = observe(e.which, e.kind); checks++;
        if (got !== e.value) begin failures++; $display("FAIL %s[%0d] got=%h exp=%h", e.name, i, got, e.value); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_in_stall();
    exp_t e;
    logic [15:0] got;
    settle_clear();
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin
          set_lu();
          expect_val("br_pre_stall", 3, 0, mk(STALL, 2'b00, 2'b00, 0, 0));
        end
        1: begin
          set_lu(); br_taken = 1;
          expect_val("br_override", 3, 0, mk(BRF, 2'b00, 2'b00, 0, 0));
          expect_val("br_flush_before", 3, 2, 16'd0);
        end
        default: begin
          expect_val("br_back_to_run", 3, 0, mk(NONE, 2'b00, 2'b00, 0, 0));
          expect_val("br_flush_cnt", 3, 2, 16'd1);
          expect_val("br_stall_cnt", 3, 1, 16'd1);
        end
      endcase
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = observe(e.which, e.kind); checks++;
        if (got !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, got, e.value); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forwarding();
    exp_t e;
    logic [15:0] got;
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin
          mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1; ex_rs = 5;
          expect_val("fwd_mem_prio", 1, 0, mk(NONE, 2'b10, 2'b00, 0, 0));
        end
        1: begin
          mem_rd = 0; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1; ex_rs = 5;
          expect_val("fwd_wb_when_mem_r0", 1, 0, mk(NONE, 2'b01, 2'b00, 0, 0));
        end
        2: begin
          mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1; ex_rs = 0;
          expect_val("fwd_src_r0", 1, 0, mk(NONE, 2'b00, 2'b00, 0, 0));
        end
        3: begin
          ex_rs = 7; ex_rt = 5; mem_rd = 5; mem_regwrite = 1; mem_memread = 1;
          wb_rd = 5; wb_regwrite = 1; id_rs = 5; id_rt = 0;
          expect_val("fwd_load_in_mem", 1, 0, mk(NONE, 2'b00, 2'b01, 1, 0));
        end
        4: begin
          wb_rd = 0; wb_regwrite = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_uses_rs = 1;
          expect_val("fwd_r0_no_hazard", 1, 0, mk(NONE, 2'b00, 2'b00, 0, 0));
        end
        default: begin
          mem_rd = 3; mem_regwrite = 1; ex_rs = 3; ex_rt = 3; wb_rd = 3; wb_regwrite = 1; id_rt = 3;
          expect_val("fwd_both_mem", 1, 0, mk(NONE, 2'b10, 2'b10, 0, 1));
        end
      endcase
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = observe(e.which, e.kind); checks++;
        if (got !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, got, e.value); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ext_stall();
    exp_t e;
    logic [15:0] got;
    settle_clear();
    for (int i = 0; i < 10; i++) begin
      idle();
      case (i)
        0: begin
          set_lu();
          expect_val("frz_pre_stall", 3, 0, mk(STALL, 2'b00, 2'b00, 0, 0));
        end
        1, 2, 3, 4: begin
          ext_stall = 1;
          if (i == 2) begin br_taken = 1; jump_id = 1; end
          if (i == 3) set_lu();
          expect_val("frz_hold", 3, 0, mk(FRZ, 2'b00, 2'b00, 0, 0));
          expect_val("frz_stall_cnt", 3, 1, 16'd1);
          expect_val("frz_flush_cnt", 3, 2, 16'd0);
        end
        5, 6: begin
          expect_val("frz_resume_stall", 3, 0, mk(STALL, 2'b00, 2'b00, 0, 0));
          expect_val("frz_resume_cnt", 3, 1, 16'(i - 4));
        end
        7: begin
          expect_val("frz_run", 3, 0, mk(NONE, 2'b00, 2'b00, 0, 0));
          expect_val("frz_total_cnt", 3, 1, 16'd3);
        end
        8: begin
          ext_stall = 1; clr_cnt = 1;
          expect_val("frz_clr_ctrl", 3, 0, mk(FRZ, 2'b00, 2'b00, 0, 0));
        end
        default: begin
          expect_val("frz_clr_cnt", 3, 1, 16'd0);
        end
      endcase
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = observe(e.which, e.kind); checks++;
        if (got !== e.value) begin failures++; $display("FAIL %s[%0d] got=%h exp=%h", e.name, i, got, e.value); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [15:0] got;
    settle_clear();
    for (int i = 0; i < 18; i++) begin
      idle();
      set_lu();
      expect_val("sat_ctrl", 2, 0, mk(STALL, 2'b00, 2'b00, 0, 0));
      expect_val("sat_stall_cnt", 2, 1, (i > 15) ? 16'd15 : 16'(i));
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = observe(e.which, e.kind); checks++;
        if (got !== e.value) begin failures++; $display("FAIL %s[%0d] got=%h exp=%h", e.name, i, got, e.value); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    logic [15:0] got;
    settle_clear();
    for (int i = 0; i < 2; i++) begin
      idle();
      if (i == 0) begin
        set_lu();
        jump_id = 1;
        expect_val("mid_pre_stall", 3, 0, mk(STALL, 2'b00, 2'b00, 0, 0));
        @(negedge clk);
      end else begin
        jump_id = 1;
        @(posedge clk); #1;
        jump_id = 0;
        reset = 0;
        #1;
        expect_val("mid_rst_ctrl", 3, 0, mk(NONE, 2'b00, 2'b00, 0, 0));
        expect_val("mid_rst_stall", 3, 1, 16'd0);
        expect_val("mid_rst_flush", 3, 2, 16'd0);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = observe(e.which, e.kind); checks++;
        if (got !== e.value) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, got, e.value); end
      end
      if (i == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load_use_lat1();
    test_load_use_lat3_jump();
    test_branch_in_stall();
    test_forwarding();
    test_ext_stall();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
